exec_seq: RTL and testbench

//  Multi-cycle sequencer for the npc core: fetch -> decode/execute -> memory -> writeback.

---
 rtl/exec_seq.sv | 156 +++++++++++++++
 tb/tb_exec_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_seq.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the npc core.
// Owns pc and ir, converts decoder flags into single-cycle strobes, and stops on ebreak or trap.
module exec_seq #(
  parameter int unsigned          XLEN     = 64,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     inst,
  input  logic            is_ebreak,
  input  logic            inst_not_ipl,
  input  logic            reg_wen,
  input  logic            mem_wen,
  input  logic [7:0]      wmask,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] next_pc,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_ack,
  output logic            rf_wen,
  output logic            retire,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            trap
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_I,
    S_EXEC,
    S_MEM,
    S_WAIT_D,
    S_WB,
    S_HALT,
    S_TRAP
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [XLEN-1:0]   dwdata_q, dwdata_d;
  logic [7:0]        dwmask_q, dwmask_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    npc_d          = npc_q;
    daddr_d        = daddr_q;
    dwdata_d       = dwdata_q;
    dwmask_d       = dwmask_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    rf_wen         = 1'b0;
    retire         = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_TRAP;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = S_WAIT_I;
        end
      end
      S_WAIT_I: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        npc_d = next_pc;
        if (inst_not_ipl) begin
          state_d = S_TRAP;
        end else if (is_ebreak) begin
          state_d = S_HALT;
        end else if (mem_wen) begin
          daddr_d  = alu_result;
          dwdata_d = rs2_data;
          dwmask_d = wmask;
          state_d  = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        // Only an ack arriving after the request was accepted completes the store.
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        rf_wen  = reg_wen;
        retire  = 1'b1;
        pc_d    = npc_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (rst) begin
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      rf_wen         = 1'b0;
      retire         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= NOP;
      npc_q    <= RESET_PC;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwmask_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      npc_q    <= npc_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dwmask_q <= dwmask_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = ir_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_wmask = dwmask_q;
  assign halted     = (state_q == S_HALT);
  assign trap       = (state_q == S_TRAP);

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: directed programs with configurable memory wait states,
// a transaction-level model checked every cycle, plus literal expectations.
module tb_exec_seq;
  localparam logic [63:0] RPC    = 64'h8000_0000;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] SD0    = 32'h0020_b023;
  localparam logic [31:0] SD8    = 32'h0020_b423;
  localparam logic [31:0] JAL    = 32'h0000_006f;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ILL    = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rsp_data = '0, inst;
  logic        is_ebreak, inst_not_ipl, reg_wen, mem_wen;
  logic [7:0]  wmask, dmem_wmask;
  logic [63:0] alu_result, rs2_data, next_pc, dmem_addr, dmem_wdata, pc;
  logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_ack = 1'b0;
  logic        rf_wen, retire, halted, trap;

  int unsigned checks = 0, errors = 0;
  int unsigned i_ready_wait = 0, i_rsp_wait = 0, d_ready_wait = 0, d_ack_wait = 0;
  bit          d_early = 0, npc_ov_en = 0;
  logic [63:0] npc_ov = '0, tb_alu = '0, tb_rs2 = '0;
  logic [31:0] imem_mem [logic [63:0]];

  always #5 clk = ~clk;

  exec_seq #(.XLEN(64), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(inst),
    .is_ebreak(is_ebreak), .inst_not_ipl(inst_not_ipl), .reg_wen(reg_wen), .mem_wen(mem_wen),
    .wmask(wmask), .alu_result(alu_result), .rs2_data(rs2_data), .next_pc(next_pc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
    .rf_wen(rf_wen), .retire(retire), .pc(pc), .halted(halted), .trap(trap)
  );

  function automatic logic [31:0] imem_at(input logic [63:0] a);
    if (imem_mem.exists(a)) return imem_mem[a];
    return 32'h0000_0013;
  endfunction

  // Minimal decoder and external next-pc adder
  assign is_ebreak    = (inst == EBREAK);
  assign inst_not_ipl = (inst == ILL);
  assign mem_wen      = (inst[6:0] == 7'b0100011) && !inst_not_ipl;
  assign wmask        = mem_wen ? 8'hff : 8'h00;
  assign reg_wen      = !mem_wen && !is_ebreak && !inst_not_ipl;
  assign alu_result   = tb_alu;
  assign rs2_data     = tb_rs2;
  assign next_pc      = npc_ov_en ? npc_ov : pc + 64'd4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory responder
  int unsigned ir_cnt = 0, irsp_cnt = 0;
  bit          ipend = 0;
  logic [63:0] i_addr_l = '0;
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (rst) begin
      imem_req_ready = 1'b0; ipend = 0; ir_cnt = 0;
    end else begin
      if (imem_req_ready) begin
        imem_req_ready = 1'b0; ipend = 1; irsp_cnt = i_rsp_wait;
      end
      if (ipend) begin
        if (irsp_cnt == 0) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = imem_at(i_addr_l); ipend = 0;
        end else irsp_cnt--;
      end
      if (imem_req_valid) begin
        if (ir_cnt < i_ready_wait) ir_cnt++;
        else begin imem_req_ready = 1'b1; ir_cnt = 0; i_addr_l = imem_addr; end
      end
    end
  end

  // Data memory responder; a pending ack survives reset to model a late response
  int unsigned dr_cnt = 0, dack_cnt = 0;
  bit          dpend = 0;
  always @(negedge clk) begin
    dmem_ack = 1'b0;
    if (dmem_req_ready) begin
      dmem_req_ready = 1'b0; dpend = 1; dack_cnt = d_ack_wait;
    end
    if (dpend) begin
      if (dack_cnt == 0) begin dmem_ack = 1'b1; dpend = 0; end
      else dack_cnt--;
    end
    if (rst) dr_cnt = 0;
    else if (dmem_req_valid) begin
      if (dr_cnt < d_ready_wait) dr_cnt++;
      else begin
        dmem_req_ready = 1'b1; dr_cnt = 0;
        if (d_early) dmem_ack = 1'b1;
      end
    end
  end

  // Transaction-level model: pc advances only at retire, latency follows the wait-state budget
  int unsigned cyc = 0, start_cyc = 0, exp_lat;
  logic [63:0] exp_pc = RPC;
  logic [31:0] m_cur;
  bit          m_st, in_flight = 0, prev_ret = 0, prev_halt = 0, prev_trap = 0;
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      exp_pc = RPC; in_flight = 0; prev_ret = 0; prev_halt = 0; prev_trap = 0;
    end else begin
      m_cur = imem_at(exp_pc);
      m_st  = (m_cur[6:0] == 7'b0100011);
      chk("model_pc", pc, exp_pc);
      if (imem_req_valid) begin
        chk("imem_addr", imem_addr, exp_pc);
        chk("fetch_allowed", 64'(exp_pc[1:0] == 2'b00 && !halted && !trap), 64'd1);
        if (!in_flight) begin in_flight = 1; start_cyc = cyc; end
      end
      if (dmem_req_valid) begin
        chk("dmem_addr", dmem_addr, tb_alu);
        chk("dmem_wdata", dmem_wdata, tb_rs2);
        chk("dmem_wmask", 64'(dmem_wmask), 64'hff);
        chk("dmem_allowed", 64'(m_st && in_flight), 64'd1);
      end
      chk("rf_wen_outside_wb", 64'(rf_wen && !retire), 64'd0);
      if (retire) begin
        exp_lat = 4 + i_ready_wait + i_rsp_wait + (m_st ? 2 + d_ready_wait + d_ack_wait : 0);
        chk("retire_back_to_back", 64'(prev_ret), 64'd0);
        chk("retire_in_flight", 64'(in_flight), 64'd1);
        chk("latency", 64'(cyc - start_cyc + 1), 64'(exp_lat));
        chk("rf_wen", 64'(rf_wen), 64'(!m_st));
        exp_pc    = npc_ov_en ? npc_ov : exp_pc + 64'd4;
        in_flight = 0;
      end
      chk("halted_legal", 64'(halted && m_cur != EBREAK), 64'd0);
      chk("halted_sticky", 64'(prev_halt && !halted), 64'd0);
      chk("trap_legal", 64'(trap && m_cur != ILL && m_cur[1:0] == 2'b11 && exp_pc[1:0] == 2'b00), 64'd0);
      chk("trap_sticky", 64'(prev_trap && !trap), 64'd0);
      prev_ret = retire; prev_halt = halted; prev_trap = trap;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i_ready_wait = 0; i_rsp_wait = 0; d_ready_wait = 0; d_ack_wait = 0;
    d_early = 0; npc_ov_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned seen, rcyc, nreq, nrf, nret, nd, nack;
    logic [63:0] cap_addr, cap_data, cap_mask;
    imem_mem[RPC]      = ADDI;
    imem_mem[RPC + 4]  = SD0;
    imem_mem[RPC + 8]  = SD8;
    imem_mem[RPC + 12] = JAL;
    tb_alu = 64'h8000_1000; tb_rs2 = 64'hdead_beef; d_ready_wait = 3;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_trap", 64'(trap), 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_dmem_wmask", 64'(dmem_wmask), 0);
    chk("rst_reqs", 64'({imem_req_valid, dmem_req_valid, rf_wen, retire}), 0);
    rst = 1'b0;

    // addi with zero-wait memory
    seen = 0; rcyc = 0;
    for (int c = 1; c <= 12 && seen == 0; c++) begin
      @(negedge clk); #3;
      if (c == 1) begin
        chk("t1_req", 64'(imem_req_valid), 1);
        chk("t1_addr", imem_addr, 64'h8000_0000);
      end
      if (retire) begin seen = 1; rcyc = c; chk("t1_rf_wen", 64'(rf_wen), 1); end
    end
    chk("t1_retire_seen", seen, 1);
    chk("t1_retire_cycle", rcyc, 4);
    @(posedge clk); #1;
    chk("t1_pc", pc, 64'h8000_0004);

    // sd with dmem ready delayed 3 cycles
    seen = 0; nreq = 0; nrf = 0; cap_addr = '0; cap_data = '0; cap_mask = '0;
    for (int c = 1; c <= 30 && seen == 0; c++) begin
      @(negedge clk); #3;
      if (dmem_req_valid) begin
        if (nreq == 0) begin cap_addr = dmem_addr; cap_data = dmem_wdata; cap_mask = 64'(dmem_wmask); end
        nreq++;
      end
      if (rf_wen) nrf++;
      if (retire) seen = 1;
    end
    chk("t2_retire_seen", seen, 1);
    chk("t2_req_cycles", nreq, 4);
    chk("t2_addr", cap_addr, 64'h8000_1000);
    chk("t2_wdata", cap_data, 64'h0000_0000_dead_beef);
    chk("t2_wmask", cap_mask, 64'hff);
    chk("t2_rf_wen", nrf, 0);

    // second sd: early ack alongside ready must be ignored, plus 2 ack waits
    tb_alu = 64'h8000_1008; tb_rs2 = 64'h0123_4567_89ab_cdef; d_ack_wait = 2; d_early = 1;
    seen = 0; rcyc = 0;
    for (int c = 1; c <= 30 && seen == 0; c++) begin
      @(negedge clk); #3;
      if (retire) begin seen = 1; rcyc = c; end
    end
    chk("t2b_retire_cycle", rcyc, 11);

    // jal to a misaligned target, with imem waits
    npc_ov_en = 1; npc_ov = 64'h8000_0002; i_ready_wait = 1; i_rsp_wait = 2;
    seen = 0; rcyc = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk); #3;
      if (retire) begin seen = 1; rcyc = c; end
    end
    chk("t5_jal_retire_cycle", rcyc, 7);
    nreq = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #3;
      if (imem_req_valid) nreq++;
    end
    chk("t5_no_fetch", nreq, 0);
    chk("t5_trap", 64'(trap), 1);
    chk("t5_pc", pc, 64'h8000_0002);

    // ebreak
    imem_mem[RPC] = EBREAK;
    do_reset();
    nreq = 0; nret = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk); #3;
      if (imem_req_valid) nreq++;
      if (retire) nret++;
      if (c == 3) chk("t3_halted_exec", 64'(halted), 0);
      if (c == 4) chk("t3_halted", 64'(halted), 1);
    end
    chk("t3_fetches", nreq, 1);
    chk("t3_retires", nret, 0);
    chk("t3_pc", pc, RPC);

    // illegal instruction
    imem_mem[RPC] = ILL;
    do_reset();
    nrf = 0; nret = 0; nd = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk); #3;
      if (rf_wen) nrf++;
      if (retire) nret++;
      if (dmem_req_valid) nd++;
      if (c == 4) chk("t4_trap", 64'(trap), 1);
    end
    chk("t4_rf_wen", nrf, 0);
    chk("t4_retire", nret, 0);
    chk("t4_dmem", nd, 0);
    chk("t4_halted", 64'(halted), 0);

    // reset while waiting for a store ack; the ack then arrives late
    imem_mem[RPC] = SD0;
    imem_mem[RPC + 4] = EBREAK;
    do_reset();
    d_ack_wait = 4; tb_alu = 64'h8000_2000; tb_rs2 = 64'h55;
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk); #3;
      if (dmem_req_valid && dmem_req_ready) seen = 1;
    end
    chk("t6_store_handshake", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    imem_mem[RPC] = ADDI;
    @(posedge clk); #1;
    chk("t6_pc", pc, RPC);
    chk("t6_dmem_req", 64'(dmem_req_valid), 0);
    chk("t6_imem_req", 64'(imem_req_valid), 0);
    chk("t6_dmem_addr", dmem_addr, 0);
    rst = 1'b0;
    nd = 0; nret = 0; nack = 0; rcyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #3;
      if (dmem_req_valid) nd++;
      if (dmem_ack) nack++;
      if (retire) begin nret++; if (rcyc == 0) rcyc = c; end
    end
    chk("t6_late_ack_seen", nack, 1);
    chk("t6_no_dmem", nd, 0);
    chk("t6_retires", nret, 1);
    chk("t6_retire_cycle", rcyc, 4);
    chk("t6_halt_pc", pc, RPC + 64'd4);
    chk("t6_halted", 64'(halted), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
